keypad_time_loader: RTL and testbench
=====================================

Name: keypad_time_loader

Overview:
- Consumes `bcd`/`data_valid` from the microwave keypad priority encoder.
- Turns each discrete key press into one digit shifted into a 4-digit MM:SS BCD entry buffer.
- Feeds the cook timer load path and the display.
- Synchronises the asynchronous keypad outputs, accepts exactly one digit per press, suppresses leading zeros and saturates at four digits.

Parameters:
- `MAX_DIGITS`, 4: number of digits accepted before entry is full (1..4).
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a press; used only when `KEY_DEBOUNCE_EN` is defined (1..15).

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `load_en`  input  1  entry allowed (oven idle, not cooking); active-high.
- `clear_entry`  input  1  synchronous clear of entry buffer (Clear key).
- `bcd`  input  4  digit code from priority encoder.
- `data_valid`  input  1  encoder reports a key held.
- `sec_ones`  output  4  seconds units digit.
- `sec_tens`  output  4  seconds tens digit.
- `min_ones`  output  4  minutes units digit.
- `min_tens`  output  4  minutes tens digit.
- `digit_count`  output  3  digits accepted so far (0..`MAX_DIGITS`).
- `entry_full`  output  1  high when `digit_count == MAX_DIGITS`.
- `digit_strobe`  output  1  one-cycle pulse when a digit is accepted.

Behaviour:
- Reset (async, any time): all digit outputs 0, `digit_count` 0, `entry_full` 0, `digit_strobe` 0, synchronisers 0, FSM to IDLE.
- Synchroniser:
  - Two-flop synchroniser on `data_valid`, producing `dv_s`.
  - `bcd` is sampled through two flops in parallel, producing `bcd_s`.
  - The FSM uses only `dv_s` and `bcd_s`.
- FSM states: IDLE, DEBOUNCE (only with the macro), WAIT_RELEASE.
- IDLE, with `dv_s` = 1 and `load_en` = 1: accept attempt (below), then go to WAIT_RELEASE.
- IDLE, with `dv_s` = 1 and `load_en` = 0: go to WAIT_RELEASE with no accept, so a held key is never captured later.
- WAIT_RELEASE: stay until `dv_s` = 0, then go to IDLE. One press yields at most one digit regardless of hold time.
- Accept attempt, performed on the same edge that leaves IDLE:
  - If `bcd_s` > 9, ignore it (no change, no strobe).
  - If `bcd_s` = 0 and `digit_count` = 0, ignore it (leading-zero suppression, no strobe).
  - If `digit_count` = `MAX_DIGITS`, ignore it (no strobe).
  - Otherwise shift left: `min_tens`<=`min_ones`, `min_ones`<=`sec_tens`, `sec_tens`<=`sec_ones`, `sec_ones`<=`bcd_s`. Then `digit_count`+1 and `digit_strobe`=1 for exactly one cycle.
- Latency without the macro: `data_valid` high before edge N gives updated digits and `digit_strobe` visible after edge N+2.
- No range check on seconds tens: 99 seconds is legal entry. Normalisation is the timer's job.
- `entry_full` is a registered compare, updated on the same edge as `digit_count`.
- `clear_entry` = 1 on an edge:
  - Digits and `digit_count` go to 0 and `digit_strobe` = 0. Clear has priority over a simultaneous accept.
  - The FSM goes to WAIT_RELEASE if `dv_s` = 1, else IDLE.
- `load_en` dropping mid-press in WAIT_RELEASE: no effect; the release is still awaited.
- Digit registers hold their value while `load_en` = 0. They are not cleared.

Optional Feature:
- `KEY_DEBOUNCE_EN` defined:
  - From IDLE, `dv_s` = 1 enters DEBOUNCE and loads a counter with `DEBOUNCE_CYCLES`-1.
  - Each cycle with `dv_s` = 1 and `bcd_s` equal to the value latched on entry, decrement the counter. At 0, perform the accept attempt and go to WAIT_RELEASE.
  - `dv_s` = 0 returns to IDLE with no accept.
  - A `bcd_s` change reloads the counter and latches the new code.
  - `load_en` = 0 during DEBOUNCE aborts to WAIT_RELEASE.
  - Added latency: `DEBOUNCE_CYCLES` cycles.
- Macro undefined: DEBOUNCE state and counter absent. Accept happens directly from IDLE as above.

Test Plan:
- Reset, `load_en`=1, press 1, 2, 3, 0 (each `data_valid` high 5 cycles, low 5 cycles) -> digits 1,2,3,0 (12:30), `digit_count`=4, `entry_full`=1, four `digit_strobe` pulses, each 3 cycles after press start.
- Press 0, 0, 5 from empty -> only 5 accepted; `sec_ones`=5, `digit_count`=1, one strobe.
- Hold key 7 for 50 cycles -> exactly one strobe, `sec_ones`=7. Fifth press on a full buffer (1,2,3,4 then 9) -> 12:34 unchanged, no strobe.
- `clear_entry` pulse on the same edge as an accept of 8 with count 2 -> all digits 0, count 0, no strobe. Key still held -> no capture until released and pressed again.
- `load_en`=0 while pressing 6 -> no change. Raise `load_en` while 6 is still held -> no capture. Assert `rst` mid-press -> all outputs 0 immediately, without waiting for a clock edge.
- With `KEY_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4: `data_valid` glitch of 2 cycles -> ignored. `bcd` switching 3->4 mid-debounce -> only 4 captured, after 4 stable cycles.

Source files
------------

// File: rtl/keypad_time_loader.sv
// Keypad digit loader: synchronises encoder outputs and shifts one digit per press into an MM:SS BCD buffer.
// Optional press debounce is compiled in with `define KEY_DEBOUNCE_EN.
module keypad_time_loader #(
  parameter int MAX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic       clear_entry,
  input  logic [3:0] bcd,
  input  logic       data_valid,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [2:0] digit_count,
  output logic       entry_full,
  output logic       digit_strobe
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  if (MAX_DIGITS < 1 || MAX_DIGITS > 4 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_param_check
    $error("keypad_time_loader: parameter out of range");
  end

`ifdef KEY_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE} state_t;
  localparam logic [3:0] DEB_LOAD = 4'(DEBOUNCE_CYCLES - 1);
  logic [3:0] deb_cnt_q, deb_cnt_d;
  logic [3:0] deb_code_q, deb_code_d;
`else
  typedef enum logic {IDLE, WAIT_RELEASE} state_t;
`endif

  state_t      state_q, state_d;
  logic        dv_m_q, dv_s_q;
  logic [3:0]  bcd_m_q, bcd_s_q;
  logic [15:0] digits_q, digits_d;   // {min_tens, min_ones, sec_tens, sec_ones}
  logic [2:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        strobe_q, strobe_d;
  logic        accept_req;
  logic        accept_ok;

  assign accept_ok = (bcd_s_q <= 4'd9) && !((bcd_s_q == 4'd0) && (count_q == 3'd0))
                     && (count_q < MAX_CNT);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    count_d    = count_q;
    strobe_d   = 1'b0;
    accept_req = 1'b0;
`ifdef KEY_DEBOUNCE_EN
    deb_cnt_d  = deb_cnt_q;
    deb_code_d = deb_code_q;
`endif
    case (state_q)
      IDLE: begin
        if (dv_s_q) begin
`ifdef KEY_DEBOUNCE_EN
          if (load_en) begin
            state_d    = DEBOUNCE;
            deb_cnt_d  = DEB_LOAD;
            deb_code_d = bcd_s_q;
          end else begin
            state_d = WAIT_RELEASE;
          end
`else
          accept_req = load_en;
          state_d    = WAIT_RELEASE;
`endif
        end
      end
`ifdef KEY_DEBOUNCE_EN
      DEBOUNCE: begin
        if (!dv_s_q) begin
          state_d = IDLE;
        end else if (!load_en) begin
          state_d = WAIT_RELEASE;
        end else if (bcd_s_q != deb_code_q) begin
          deb_cnt_d  = DEB_LOAD;
          deb_code_d = bcd_s_q;
        end else if (deb_cnt_q == 4'd0) begin
          accept_req = 1'b1;
          state_d    = WAIT_RELEASE;
        end else begin
          deb_cnt_d = deb_cnt_q - 4'd1;
        end
      end
`endif
      WAIT_RELEASE: begin
        if (!dv_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept_req && accept_ok) begin
      digits_d = {digits_q[11:0], bcd_s_q};
      count_d  = count_q + 3'd1;
      strobe_d = 1'b1;
    end

    // Clear wins over a same-edge accept; a still-held key must be released first.
    if (clear_entry) begin
      digits_d = '0;
      count_d  = '0;
      strobe_d = 1'b0;
      state_d  = dv_s_q ? WAIT_RELEASE : IDLE;
    end
  end

  assign full_d = (count_d == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_m_q   <= 1'b0;
      dv_s_q   <= 1'b0;
      bcd_m_q  <= '0;
      bcd_s_q  <= '0;
      state_q  <= IDLE;
      digits_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      dv_m_q   <= data_valid;
      dv_s_q   <= dv_m_q;
      bcd_m_q  <= bcd;
      bcd_s_q  <= bcd_m_q;
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      full_q   <= full_d;
      strobe_q <= strobe_d;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      deb_code_q <= '0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      deb_code_q <= deb_code_d;
    end
  end
`endif

  assign sec_ones     = digits_q[3:0];
  assign sec_tens     = digits_q[7:4];
  assign min_ones     = digits_q[11:8];
  assign min_tens     = digits_q[15:12];
  assign digit_count  = count_q;
  assign entry_full   = full_q;
  assign digit_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Scoreboard bench for keypad_time_loader: each accepted press pushes its expected digits and strobe cycle.
module tb_keypad_time_loader;

  localparam int MAX = 4;
  localparam int DEB = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic       clear_entry = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       data_valid = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [2:0] digit_count;
  logic       entry_full, digit_strobe;

  keypad_time_loader #(.MAX_DIGITS(MAX), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .clear_entry(clear_entry),
    .bcd(bcd), .data_valid(data_valid),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .digit_count(digit_count), .entry_full(entry_full), .digit_strobe(digit_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    int          count;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] m_digits = '0;
  int          m_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_value({tag, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, m_digits);
    check_value({tag, "_count"}, digit_count, m_count);
    check_value({tag, "_full"}, entry_full, (m_count == MAX));
  endtask

  function automatic bit model_accepts(input logic [3:0] key);
    return load_en && (key <= 4'd9) && !(key == 4'd0 && m_count == 0) && (m_count < MAX);
  endfunction

  function automatic void model_shift(input logic [3:0] key, input int due);
    m_digits = {m_digits[11:0], key};
    m_count++;
    exp_q.push_back('{m_digits, m_count, due});
  endfunction

  task automatic press(input logic [3:0] key, input int hold, input int gap);
    @(negedge clk);
    bcd = key;
    data_valid = 1'b1;
    if (model_accepts(key)) model_shift(key, cyc + LAT);
    $display("press key=%0d hold=%0d load_en=%0b start=%0d", key, hold, load_en, cyc);
    repeat (hold) @(negedge clk);
    data_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    m_digits = '0;
    m_count = 0;
    $display("clear at cycle %0d", cyc);
  endtask

  // Strobe monitor: each pulse must match the oldest pending expectation, on its cycle.
  always @(negedge clk) begin
    if (!rst && digit_strobe) begin
      if (exp_q.size() == 0) begin
        check_value("unexpected_strobe", digit_strobe, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("strobe cycle=%0d digits=%0h count=%0d", cyc, {min_tens, min_ones, sec_tens, sec_ones}, digit_count);
        check_value("strobe_digits", {min_tens, min_ones, sec_tens, sec_ones}, e.digits);
        check_value("strobe_count", digit_count, e.count);
        check_value("strobe_full", entry_full, (e.count == MAX));
        check_value("strobe_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check_value("reset_strobe", digit_strobe, 1'b0);
    rst = 1'b0;
    load_en = 1'b1;

    press(4'd1, HOLD, 5); press(4'd2, HOLD, 5); press(4'd3, HOLD, 5); press(4'd0, HOLD, 5);
    check_outputs("seq_1230");

    do_clear();
    check_outputs("after_clear");
    press(4'd0, HOLD, 5); press(4'd0, HOLD, 5); press(4'd5, HOLD, 5);
    check_outputs("leading_zero");

    do_clear();
    press(4'd7, 50, 5);
    check_outputs("long_hold");

    do_clear();
    press(4'd1, HOLD, 5); press(4'd2, HOLD, 5); press(4'd3, HOLD, 5); press(4'd4, HOLD, 5);
    press(4'd9, HOLD, 5);
    check_outputs("full_ignore");

    do_clear();
    press(4'd1, HOLD, 5); press(4'd2, HOLD, 5);
    press(4'd12, HOLD, 5);
    check_outputs("invalid_code");
    // Clear lands on the same edge the non-debounced loader would accept 8.
    @(negedge clk);
    bcd = 4'd8;
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    clear_entry = 1'b1;
    @(negedge clk);
    clear_entry = 1'b0;
    m_digits = '0;
    m_count = 0;
    check_value("clear_race_strobe", digit_strobe, 1'b0);
    check_outputs("clear_race");
    repeat (15) @(negedge clk);
    check_outputs("clear_held");
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    press(4'd8, HOLD, 5);
    check_outputs("repress_8");

    load_en = 1'b0;
    press(4'd6, HOLD, 5);
    check_outputs("load_dis");
    @(negedge clk);
    bcd = 4'd6;
    data_valid = 1'b1;
    repeat (5) @(negedge clk);
    load_en = 1'b1;
    repeat (15) @(negedge clk);
    check_outputs("enable_while_held");

    @(negedge clk);
    #1 rst = 1'b1;
    m_digits = '0;
    m_count = 0;
    #1;
    check_outputs("async_rst");
    check_value("async_rst_strobe", digit_strobe, 1'b0);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    press(4'd9, HOLD, 5);
    check_outputs("after_rst");

`ifdef KEY_DEBOUNCE_EN
    do_clear();
    @(negedge clk);
    bcd = 4'd5;
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    data_valid = 1'b0;
    repeat (12) @(negedge clk);
    check_outputs("glitch");
    @(negedge clk);
    bcd = 4'd3;
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    bcd = 4'd4;
    model_shift(4'd4, cyc + LAT);
    repeat (14) @(negedge clk);
    data_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_outputs("code_switch");
`endif

    repeat (5) @(negedge clk);
    check_value("missing_strobes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
